blockram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives a `dual_port_blockram` as its storage array: port A is the write port, port B the read port. It converts the RAM's one-cycle registered read into a valid/ready stream. It sits directly upstream of the blockram, feeding its port pins, and in front of any consumer that needs queued 64-bit entries.

---
 rtl/blockram_fifo_ctrl_pkg.sv | 8 +
 rtl/dual_port_blockram.sv | 51 +++++
 rtl/fifo_output_skid_buffer.sv | 46 ++++
 rtl/blockram_fifo_ctrl.sv | 109 ++++++++++
 tb/tb_blockram_fifo_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blockram_fifo_ctrl_pkg.sv
// rtl/blockram_fifo_ctrl_pkg.sv - shared constants for the blockram FIFO controller slice
package blockram_fifo_ctrl_pkg;

    localparam int BYTE_LEN_IN_BITS    = 8;
    localparam int DEFAULT_ENTRY_WIDTH = 64;
    localparam int DEFAULT_NUM_SET     = 64;

endpackage

// File: rtl/dual_port_blockram.sv
// rtl/dual_port_blockram.sv - two-port byte-maskable RAM with one-cycle registered reads
module dual_port_blockram
    import blockram_fifo_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH,
    parameter int NUM_SET                    = DEFAULT_NUM_SET,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                  clk_in,
    input  logic                                  port_A_access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]             port_A_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      port_A_access_set_addr_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] port_A_write_entry_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] port_A_read_entry_out,
    output logic                                  port_A_read_valid_out,
    input  logic                                  port_B_access_en_in,
    input  logic [WRITE_MASK_LEN-1:0]             port_B_write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      port_B_access_set_addr_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] port_B_write_entry_in,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] port_B_read_entry_out,
    output logic                                  port_B_read_valid_out
);

    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem [NUM_SET];

    // Byte-masked writes and registered reads on both ports; contents are never cleared.
    always_ff @(posedge clk_in) begin
        port_A_read_valid_out <= port_A_access_en_in && (port_A_write_en_in == '0);
        port_B_read_valid_out <= port_B_access_en_in && (port_B_write_en_in == '0);
        if (port_A_access_en_in) begin
            port_A_read_entry_out <= mem[port_A_access_set_addr_in];
            for (int b = 0; b < WRITE_MASK_LEN; b++) begin
                if (port_A_write_en_in[b]) begin
                    mem[port_A_access_set_addr_in][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <=
                        port_A_write_entry_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
                end
            end
        end
        if (port_B_access_en_in) begin
            port_B_read_entry_out <= mem[port_B_access_set_addr_in];
            for (int b = 0; b < WRITE_MASK_LEN; b++) begin
                if (port_B_write_en_in[b]) begin
                    mem[port_B_access_set_addr_in][b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS] <=
                        port_B_write_entry_in[b*BYTE_LEN_IN_BITS +: BYTE_LEN_IN_BITS];
                end
            end
        end
    end

endmodule

// File: rtl/fifo_output_skid_buffer.sv
// rtl/fifo_output_skid_buffer.sv - 2-entry register buffer holding RAM read returns for the consumer
module fifo_output_skid_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] tail_q;

    // Head only changes on a pop or on a push into an empty buffer, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            head   <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail_q <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head   <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/blockram_fifo_ctrl.sv
// rtl/blockram_fifo_ctrl.sv - valid/ready FIFO controller driving a dual-port blockram
module blockram_fifo_ctrl
    import blockram_fifo_ctrl_pkg::*;
#(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH,
    parameter int NUM_SET                    = DEFAULT_NUM_SET,
    parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN             = SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
    input  logic                                  request_valid_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    output logic                                  request_ready_out,
    output logic                                  response_valid_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] response_out,
    input  logic                                  response_ready_in,
    output logic [SET_PTR_WIDTH_IN_BITS:0]        count_out,
    output logic                                  full_out,
    output logic                                  empty_out,
    output logic                                  port_A_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             port_A_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      port_A_access_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] port_A_write_entry_out,
    output logic                                  port_B_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]             port_B_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]      port_B_access_set_addr_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] port_B_write_entry_out,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] port_B_read_entry_in,
    input  logic                                  port_B_read_valid_in
);

    localparam int CW = SET_PTR_WIDTH_IN_BITS + 1;
    localparam logic [CW-1:0] CAPACITY = CW'(NUM_SET);

    logic [SET_PTR_WIDTH_IN_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] ram_count_q, count_q;
    logic          inflight_q;
    logic [1:0]    buf_count;
    logic [2:0]    occupancy;
    logic          enq, deq, issue, ret;

    assign count_out          = count_q;
    assign full_out           = (count_q == CAPACITY);
    assign empty_out          = (count_q == '0);
    assign request_ready_out  = !full_out;
    assign response_valid_out = (buf_count != 2'd0);

    assign enq = request_valid_in && request_ready_out;
    assign deq = response_valid_out && response_ready_in;
    assign ret = port_B_read_valid_in && inflight_q;

    // Slots the buffer will need next cycle; counting this cycle's pop lets a read be
    // issued one cycle ahead so the stream sustains one entry per cycle.
    assign occupancy = {1'b0, buf_count} + {2'b0, inflight_q} - {2'b0, deq};
    assign issue     = (ram_count_q != '0) && (occupancy < 3'd2);

    // Write port follows the enqueue handshake combinationally.
    always_comb begin
        port_A_access_en_out       = 1'b0;
        port_A_write_en_out        = '0;
        port_A_access_set_addr_out = '0;
        port_A_write_entry_out     = '0;
        if (enq) begin
            port_A_access_en_out       = 1'b1;
            port_A_write_en_out        = '1;
            port_A_access_set_addr_out = wr_ptr_q;
            port_A_write_entry_out     = request_in;
        end
    end

    // Read port issues from rd_ptr whenever buffer space is guaranteed.
    always_comb begin
        port_B_access_en_out       = issue;
        port_B_write_en_out        = '0;
        port_B_access_set_addr_out = issue ? rd_ptr_q : '0;
        port_B_write_entry_out     = '0;
    end

    // Pointer, RAM-occupancy, in-flight and total-count bookkeeping.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_count_q <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
        end else begin
            if (enq)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (issue) rd_ptr_q <= rd_ptr_q + 1'b1;
            inflight_q  <= issue;
            ram_count_q <= ram_count_q + CW'(enq) - CW'(issue);
            count_q     <= count_q + CW'(enq) - CW'(deq);
        end
    end

    fifo_output_skid_buffer #(
        .WIDTH(SINGLE_ENTRY_WIDTH_IN_BITS)
    ) u_skid (
        .clk      (clk_in),
        .reset    (reset_in),
        .push     (ret),
        .push_data(port_B_read_entry_in),
        .pop      (deq),
        .count    (buf_count),
        .head     (response_out)
    );

endmodule

// File: tb/tb_blockram_fifo_ctrl.sv
// tb/tb_blockram_fifo_ctrl.sv - directed self-checking bench for blockram_fifo_ctrl with a real blockram
module tb_blockram_fifo_ctrl;

    localparam int W  = 64;
    localparam int N  = 64;
    localparam int PW = 6;
    localparam int M  = 8;

    logic          clk;
    logic          reset_in;
    logic          request_valid_in;
    logic [W-1:0]  request_in;
    logic          request_ready_out;
    logic          response_valid_out;
    logic [W-1:0]  response_out;
    logic          response_ready_in;
    logic [PW:0]   count_out;
    logic          full_out, empty_out;
    logic          a_en, b_en;
    logic [M-1:0]  a_we, b_we;
    logic [PW-1:0] a_addr, b_addr;
    logic [W-1:0]  a_wdata, b_wdata;
    logic [W-1:0]  a_rdata, b_rdata;
    logic          a_rvalid, b_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    blockram_fifo_ctrl #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .NUM_SET(N)
    ) dut (
        .clk_in                    (clk),
        .reset_in                  (reset_in),
        .request_valid_in          (request_valid_in),
        .request_in                (request_in),
        .request_ready_out         (request_ready_out),
        .response_valid_out        (response_valid_out),
        .response_out              (response_out),
        .response_ready_in         (response_ready_in),
        .count_out                 (count_out),
        .full_out                  (full_out),
        .empty_out                 (empty_out),
        .port_A_access_en_out      (a_en),
        .port_A_write_en_out       (a_we),
        .port_A_access_set_addr_out(a_addr),
        .port_A_write_entry_out    (a_wdata),
        .port_B_access_en_out      (b_en),
        .port_B_write_en_out       (b_we),
        .port_B_access_set_addr_out(b_addr),
        .port_B_write_entry_out    (b_wdata),
        .port_B_read_entry_in      (b_rdata),
        .port_B_read_valid_in      (b_rvalid)
    );

    dual_port_blockram #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .NUM_SET(N)
    ) ram (
        .clk_in                   (clk),
        .port_A_access_en_in      (a_en),
        .port_A_write_en_in       (a_we),
        .port_A_access_set_addr_in(a_addr),
        .port_A_write_entry_in    (a_wdata),
        .port_A_read_entry_out    (a_rdata),
        .port_A_read_valid_out    (a_rvalid),
        .port_B_access_en_in      (b_en),
        .port_B_write_en_in       (b_we),
        .port_B_access_set_addr_in(b_addr),
        .port_B_write_entry_in    (b_wdata),
        .port_B_read_entry_out    (b_rdata),
        .port_B_read_valid_out    (b_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_in = 1'b1; request_valid_in = 1'b0; request_in = '0; response_ready_in = 1'b0;
        @(negedge clk); reset_in = 1'b0; #1;
        n_checks++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b expected 1", empty_out); end
        n_checks++; if (request_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", request_ready_out); end
        n_checks++; if (response_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %0b expected 0", response_valid_out); end
        n_checks++; if (count_out !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_out); end
        n_checks++; if (full_out !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full_out); end
        n_checks++; if ({a_en, b_en} !== 2'b00) begin n_fail++; $display("FAIL reset_port_en: got %0b expected 0", {a_en, b_en}); end
    endtask

    task automatic test_single_word();
        @(negedge clk); request_valid_in = 1'b1; request_in = 64'h5555_5555_5555_5555; response_ready_in = 1'b0; #1;
        n_checks++; if (a_en !== 1'b1 || a_we !== 8'hFF || a_addr !== 6'd0 || a_wdata !== 64'h5555_5555_5555_5555) begin
            n_fail++; $display("FAIL single_portA: got en=%0b we=%0h addr=%0d data=%0h expected 1 ff 0 5555555555555555", a_en, a_we, a_addr, a_wdata);
        end
        @(negedge clk); request_valid_in = 1'b0; #1;
        n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL single_portA_idle: got %0b expected 0", a_en); end
        n_checks++; if (b_en !== 1'b1 || b_addr !== 6'd0) begin n_fail++; $display("FAIL single_issue: got en=%0b addr=%0d expected 1 0", b_en, b_addr); end
        n_checks++; if (response_valid_out !== 1'b0) begin n_fail++; $display("FAIL single_lat1: got %0b expected 0", response_valid_out); end
        @(negedge clk); #1;
        n_checks++; if (response_valid_out !== 1'b0) begin n_fail++; $display("FAIL single_lat2: got %0b expected 0", response_valid_out); end
        @(negedge clk); #1;
        n_checks++; if (response_valid_out !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", response_valid_out); end
        n_checks++; if (response_out !== 64'h5555_5555_5555_5555) begin n_fail++; $display("FAIL single_data: got %0h expected 5555555555555555", response_out); end
        n_checks++; if (count_out !== 7'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count_out); end
        response_ready_in = 1'b1;
        @(negedge clk); response_ready_in = 1'b0; #1;
        n_checks++; if (empty_out !== 1'b1 || response_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got empty=%0b rvalid=%0b expected 1 0", empty_out, response_valid_out);
        end
    endtask

    task automatic test_fill_full();
        int sent = 0;
        int got  = 0;
        response_ready_in = 1'b0;
        for (int cyc = 0; cyc < 200 && sent < N; cyc++) begin
            @(negedge clk); request_valid_in = 1'b1; request_in = W'(sent); #1;
            if (request_ready_out) sent++;
        end
        n_checks++; if (sent != N) begin n_fail++; $display("FAIL fill_timeout: got %0d expected %0d", sent, N); end
        @(negedge clk); request_in = 64'hDEAD_BEEF_DEAD_BEEF; #1;
        n_checks++; if (full_out !== 1'b1 || request_ready_out !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got full=%0b ready=%0b expected 1 0", full_out, request_ready_out);
        end
        n_checks++; if (count_out !== 7'd64) begin n_fail++; $display("FAIL fill_count: got %0d expected 64", count_out); end
        @(negedge clk); #1;
        n_checks++; if (count_out !== 7'd64) begin n_fail++; $display("FAIL fill_65th: got %0d expected 64", count_out); end
        for (int cyc = 0; cyc < 300 && got < N; cyc++) begin
            @(negedge clk); response_ready_in = 1'b1;
            if (cyc == 1) request_valid_in = 1'b0;
            #1;
            if (cyc == 0) begin
                n_checks++; if (request_ready_out !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %0b expected 0", request_ready_out); end
            end
            if (cyc == 1) begin
                n_checks++; if (count_out !== 7'd63) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 63", count_out); end
            end
            if (response_valid_out) begin
                n_checks++; if (response_out !== W'(got)) begin n_fail++; $display("FAIL fill_order: got %0h expected %0h", response_out, got); end
                got++;
            end
        end
        n_checks++; if (got != N) begin n_fail++; $display("FAIL fill_drain_timeout: got %0d expected %0d", got, N); end
        @(negedge clk); response_ready_in = 1'b0; #1;
        n_checks++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %0b expected 1", empty_out); end
    endtask

    task automatic test_streaming();
        logic [W-1:0] next_in  = 64'h1000;
        logic [W-1:0] next_out = 64'h1000;
        response_ready_in = 1'b1;
        for (int k = 0; k < 210; k++) begin
            @(negedge clk); request_valid_in = (k < 200); request_in = next_in; #1;
            if (response_valid_out) begin
                n_checks++; if (response_out !== next_out) begin n_fail++; $display("FAIL stream_order: got %0h expected %0h", response_out, next_out); end
                next_out++;
            end else if (k >= 3 && k < 200) begin
                n_checks++; n_fail++; $display("FAIL stream_gap: got rvalid 0 expected 1 at cycle %0d", k);
            end
            if (count_out > 7'd3) begin
                n_checks++; n_fail++; $display("FAIL stream_count: got %0d expected <=3", count_out);
            end
            if (request_valid_in) begin
                n_checks++; if (request_ready_out !== 1'b1) begin n_fail++; $display("FAIL stream_ready: got %0b expected 1", request_ready_out); end
                next_in++;
            end
        end
        n_checks++; if (next_out !== next_in) begin n_fail++; $display("FAIL stream_total: got %0h expected %0h", next_out, next_in); end
        response_ready_in = 1'b0;
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        int recv = 0;
        logic prev_stall = 1'b0;
        logic [W-1:0] prev_data = '0;
        for (int cyc = 0; cyc < 1000 && recv < 50; cyc++) begin
            @(negedge clk);
            request_valid_in  = (sent < 50);
            request_in        = 64'hC0DE_0000_0000_0000 + W'(sent);
            response_ready_in = 1'($urandom_range(0, 1));
            #1;
            if (response_valid_out) begin
                if (prev_stall) begin
                    n_checks++; if (response_out !== prev_data) begin n_fail++; $display("FAIL bp_stable: got %0h expected %0h", response_out, prev_data); end
                end
                if (response_ready_in) begin
                    n_checks++; if (response_out !== 64'hC0DE_0000_0000_0000 + W'(recv)) begin
                        n_fail++; $display("FAIL bp_order: got %0h expected %0h", response_out, 64'hC0DE_0000_0000_0000 + W'(recv));
                    end
                    recv++;
                end
            end
            prev_stall = response_valid_out && !response_ready_in;
            prev_data  = response_out;
            if (request_valid_in && request_ready_out) sent++;
        end
        n_checks++; if (recv != 50) begin n_fail++; $display("FAIL bp_timeout: got %0d expected 50", recv); end
        @(negedge clk); request_valid_in = 1'b0; response_ready_in = 1'b0; #1;
        n_checks++; if (empty_out !== 1'b1) begin n_fail++; $display("FAIL bp_empty: got %0b expected 1", empty_out); end
    endtask

    task automatic test_mid_reset();
        int sent = 0;
        int seen = 0;
        response_ready_in = 1'b0;
        for (int cyc = 0; cyc < 50 && sent < 10; cyc++) begin
            @(negedge clk); request_valid_in = 1'b1; request_in = 64'h7000 + W'(sent); #1;
            if (request_ready_out) sent++;
        end
        for (int i = 0; i < 3; i++) begin @(negedge clk); request_valid_in = 1'b0; end
        @(negedge clk); response_ready_in = 1'b1; #1;
        n_checks++; if (b_en !== 1'b1 || response_valid_out !== 1'b1) begin
            n_fail++; $display("FAIL mr_inflight: got issue=%0b rvalid=%0b expected 1 1", b_en, response_valid_out);
        end
        @(negedge clk); reset_in = 1'b1;
        @(negedge clk); reset_in = 1'b0; #1;
        n_checks++; if (count_out !== 7'd0 || response_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL mr_after: got count=%0d rvalid=%0b expected 0 0", count_out, response_valid_out);
        end
        @(negedge clk); #1;
        n_checks++; if (response_valid_out !== 1'b0) begin n_fail++; $display("FAIL mr_drop: got %0b expected 0", response_valid_out); end
        @(negedge clk); request_valid_in = 1'b1; request_in = 64'hAAAA_AAAA_AAAA_AAAA; #1;
        n_checks++; if (a_en !== 1'b1 || a_addr !== 6'd0) begin n_fail++; $display("FAIL mr_wr_addr: got en=%0b addr=%0d expected 1 0", a_en, a_addr); end
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk); request_valid_in = 1'b0; #1;
            if (response_valid_out) begin
                n_checks++; if (response_out !== 64'hAAAA_AAAA_AAAA_AAAA) begin n_fail++; $display("FAIL mr_data: got %0h expected aaaaaaaaaaaaaaaa", response_out); end
                seen++;
            end
        end
        n_checks++; if (seen != 1) begin n_fail++; $display("FAIL mr_count: got %0d responses expected 1", seen); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_full();
        test_streaming();
        test_back_pressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
